// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro used by the top: DMEM_TIMEOUT_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Read data substituted when an I/O access is aborted.
  localparam logic [63:0] IO_ABORT_WORD = '1;

  // Width of the offset into the I/O window above io_base.
  function automatic int io_addr_bits(input int addr_width, input int base);
    int span;
    span = (1 << addr_width) - base;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, read-first, with a resettable output register.
module dmem_ram #(
  parameter int width = 16,
  parameter int depth = 240,
  localparam int aw = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic             re,
  input  logic [aw-1:0]    addr,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Separate read register: sees the old word on a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port target: RAM below io_base, stalling req/ack peripheral port above it.
// Optional macro DMEM_TIMEOUT_EN adds an I/O abort timer and timeout_flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int width       = 16,
  parameter int daddr_width = 8,
  parameter int io_base     = 'hF0
`ifdef DMEM_TIMEOUT_EN
  , parameter int timeout   = 64
`endif
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [daddr_width-1:0]                        daddr,
  input  logic                                          dwrite,
  input  logic                                          mem_read,
  input  logic [width-1:0]                              dD,
  output logic [width-1:0]                              dQ,
  output logic                                          wait_state,
  output logic                                          io_req,
  output logic                                          io_we,
  output logic [io_addr_bits(daddr_width, io_base)-1:0] io_addr,
  output logic [width-1:0]                              io_wdata,
  input  logic [width-1:0]                              io_rdata,
  input  logic                                          io_ack
`ifdef DMEM_TIMEOUT_EN
  , output logic                                        timeout_flag
`endif
);

  localparam int io_aw  = io_addr_bits(daddr_width, io_base);
  localparam int ram_aw = (io_base > 1) ? $clog2(io_base) : 1;
  localparam logic [daddr_width-1:0] io_base_a = daddr_width'(io_base);

  dmem_state_t state_reg, state_next;

  logic             io_sel, access, io_start, ram_accept, expire;
  logic             src_io_reg, io_we_reg;
  logic [io_aw-1:0] io_addr_reg;
  logic [width-1:0] io_wdata_reg, io_rdata_reg, ram_q;

  assign io_sel     = (daddr >= io_base_a);
  assign access     = dwrite | mem_read;
  assign io_start   = (state_reg == IDLE) && access && io_sel;
  assign ram_accept = (state_reg == IDLE) && access && !io_sel;

  dmem_ram #(
    .width (width),
    .depth (io_base)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_accept),
    .we    (dwrite),
    .re    (mem_read),
    .addr  (daddr[ram_aw-1:0]),
    .wdata (dD),
    .rdata (ram_q)
  );

  always_comb begin
    state_next = state_reg;
    wait_state = 1'b0;
    io_req     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (io_start) begin
          wait_state = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        io_req     = 1'b1;
        wait_state = 1'b1;
        if (io_ack || expire) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // The CPU must never be held while the responder is being reset.
    if (reset) begin
      wait_state = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      src_io_reg   <= 1'b0;
      io_we_reg    <= 1'b0;
      io_addr_reg  <= '0;
      io_wdata_reg <= '0;
      io_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (io_start) begin
        io_we_reg    <= dwrite;
        io_addr_reg  <= io_aw'(daddr - io_base_a);
        io_wdata_reg <= dD;
      end
      if ((state_reg == REQ) && io_ack && !io_we_reg) begin
        io_rdata_reg <= io_rdata;
      end else if (expire) begin
        io_rdata_reg <= IO_ABORT_WORD[width-1:0];
      end
      // DONE is the edge where the CPU consumes the I/O access.
      if (state_reg == DONE) begin
        src_io_reg <= 1'b1;
      end else if (ram_accept) begin
        src_io_reg <= 1'b0;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout) + 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout - 1);

  logic [cnt_w-1:0] cnt_reg;
  logic             flag_reg;

  // An ack on the expiry cycle takes precedence over the abort.
  assign expire       = (state_reg == REQ) && !io_ack && (cnt_reg == cnt_last);
  assign timeout_flag = flag_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else begin
      if (io_start) begin
        cnt_reg <= '0;
      end else if (state_reg == REQ) begin
        cnt_reg <= cnt_reg + cnt_w'(1);
      end
      if (expire) begin
        flag_reg <= 1'b1;
      end
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign dQ       = src_io_reg ? io_rdata_reg : ram_q;
  assign io_we    = io_we_reg;
  assign io_addr  = io_addr_reg;
  assign io_wdata = io_wdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder (timeout checks when DMEM_TIMEOUT_EN is defined).
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  daddr;
  logic        dwrite, mem_read;
  logic [15:0] dD, dQ;
  logic        wait_state, io_req, io_we;
  logic [3:0]  io_addr;
  logic [15:0] io_wdata, io_rdata;
  logic        io_ack;
`ifdef DMEM_TIMEOUT_EN
  logic        timeout_flag;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .width       (16),
    .daddr_width (8),
    .io_base     ('hF0)
`ifdef DMEM_TIMEOUT_EN
    , .timeout   (8)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .daddr      (daddr),
    .dwrite     (dwrite),
    .mem_read   (mem_read),
    .dD         (dD),
    .dQ         (dQ),
    .wait_state (wait_state),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_ack     (io_ack)
`ifdef DMEM_TIMEOUT_EN
    , .timeout_flag (timeout_flag)
`endif
  );

  typedef struct {
    int          dly;
    logic [15:0] rdata;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
  } per_t;

  int          total = 0;
  int          bad = 0;
  logic [15:0] sb_q[$];
  per_t        per_q[$];
  logic [15:0] model_mem [0:255];
  logic        acc_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read accepted at one edge must show its data the following cycle.
  always @(negedge clk) begin
    if (acc_prev) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dq_unexpected: got %h with no expected read pending", dQ);
      end else begin
        check("dQ", dQ, sb_q.pop_front());
      end
    end
    acc_prev <= mem_read && !wait_state && !reset;
  end

  // Peripheral model: acks after the requested delay unless io_req is withdrawn first.
  initial begin
    per_t e;
    io_ack = 1'b0;
    io_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (io_req) begin
        if (per_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL io_unexpected: io_req with addr %h and no access issued", io_addr);
          while (io_req) @(negedge clk);
        end else begin
          e = per_q.pop_front();
          check("io_we", io_we, e.we);
          check("io_addr", io_addr, e.addr);
          if (e.we) check("io_wdata", io_wdata, e.wdata);
          for (int k = 0; k < e.dly && io_req; k++) @(negedge clk);
          if (io_req) begin
            io_ack = 1'b1;
            io_rdata = e.rdata;
            @(negedge clk);
            io_ack = 1'b0;
            io_rdata = 16'($urandom);
          end
        end
      end
    end
  end

  // CPU-side driver: one call per access; expected values come from the model.
  task automatic access(input logic [7:0] a, input logic wr, input logic rd,
                        input logic [15:0] d, input int dly, input logic [15:0] rdat,
                        input logic tmo);
    int          waits;
    int          exp_wait;
    logic        io;
    logic [15:0] exp_q;
    per_t        e;
    io = (a >= 8'hF0);
    daddr = a;
    dwrite = wr;
    mem_read = rd;
    dD = d;
    if (io) begin
      e.dly = tmo ? 100000 : dly;
      e.rdata = rdat;
      e.we = wr;
      e.addr = 4'(a - 8'hF0);
      e.wdata = d;
      per_q.push_back(e);
      exp_wait = tmo ? 9 : 2 + dly;
      exp_q = tmo ? 16'hFFFF : rdat;
    end else begin
      exp_wait = 0;
      exp_q = model_mem[a];
      if (wr) model_mem[a] = d;
    end
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (!wait_state) break;
      waits++;
      if (waits > 500) begin
        total++;
        bad++;
        $display("FAIL stall_bound: wait_state stuck high at addr %h", a);
        break;
      end
    end
    if (rd) sb_q.push_back(exp_q);
    check("wait_cycles", waits, exp_wait);
    $display("txn addr=%h wr=%0d rd=%0d d=%h waits=%0d", a, wr, rd, d, waits);
    @(posedge clk);
    #1;
    dwrite = 1'b0;
    mem_read = 1'b0;
  endtask

  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    reset = 1'b1;
    daddr = 8'h0;
    dwrite = 1'b0;
    mem_read = 1'b0;
    dD = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dQ", dQ, 16'h0);
    check("reset_wait", wait_state, 1'b0);
    check("reset_io_req", io_req, 1'b0);
    check("reset_io_we", io_we, 1'b0);
`ifdef DMEM_TIMEOUT_EN
    check("reset_flag", timeout_flag, 1'b0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 32; i++) access(8'(i), 1'b1, 1'b0, 16'($urandom), 0, 16'h0, 1'b0);

    access(8'h10, 1'b1, 1'b0, 16'h1234, 0, 16'h0, 1'b0);
    access(8'h10, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0);
    access(8'h05, 1'b1, 1'b0, 16'hAAAA, 0, 16'h0, 1'b0);
    access(8'h05, 1'b1, 1'b1, 16'h5555, 0, 16'h0, 1'b0);
    access(8'h05, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0);
    access(8'hF2, 1'b0, 1'b1, 16'h0, 3, 16'hBEEF, 1'b0);
    access(8'hF0, 1'b1, 1'b0, 16'h00C3, 0, 16'h0, 1'b0);
    access(8'hFF, 1'b0, 1'b1, 16'h0, 0, 16'h1357, 1'b0);

    for (int i = 0; i < 150; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        a = 8'($urandom_range(0, 31));
        case ($urandom_range(0, 2))
          0:       access(a, 1'b1, 1'b0, d, 0, 16'h0, 1'b0);
          1:       access(a, 1'b0, 1'b1, d, 0, 16'h0, 1'b0);
          default: access(a, 1'b1, 1'b1, d, 0, 16'h0, 1'b0);
        endcase
      end else begin
        a = 8'($urandom_range(8'hF0, 8'hFF));
        if ($urandom_range(0, 1) == 0)
          access(a, 1'b1, 1'b0, d, $urandom_range(0, 4), 16'h0, 1'b0);
        else
          access(a, 1'b0, 1'b1, d, $urandom_range(0, 4), 16'($urandom), 1'b0);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset while a request is outstanding.
    daddr = 8'hF5;
    mem_read = 1'b1;
    dwrite = 1'b0;
    begin
      per_t e;
      e.dly = 100000;
      e.rdata = 16'h0;
      e.we = 1'b0;
      e.addr = 4'h5;
      e.wdata = 16'h0;
      per_q.push_back(e);
    end
    repeat (3) @(negedge clk);
    check("req_pending", io_req, 1'b1);
    check("wait_pending", wait_state, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("wait_during_reset", wait_state, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    check("io_req_after_reset", io_req, 1'b0);
    check("wait_after_reset", wait_state, 1'b0);
    check("dQ_after_reset", dQ, 16'h0);
    @(posedge clk);
    #1;
    access(8'h10, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0);
    access(8'h1F, 1'b1, 1'b1, 16'h4242, 0, 16'h0, 1'b0);
    access(8'h1F, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    access(8'hF3, 1'b0, 1'b1, 16'h0, 7, 16'h6789, 1'b0);
    check("flag_ack_on_expiry", timeout_flag, 1'b0);
    access(8'hF7, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b1);
    check("flag_after_timeout", timeout_flag, 1'b1);
    access(8'h03, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0);
    access(8'hF1, 1'b0, 1'b1, 16'h0, 1, 16'h2468, 1'b0);
    check("flag_sticky", timeout_flag, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("io_queue_drained", per_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
